// File: rtl/rram_pulse_ctrl.sv
// Wishbone-programmed SETUP/PULSE/HOLD sequencer driving the RRAM array selects,
// pulse enables and sense-amp strobe, with status capture and a completion interrupt.
module rram_pulse_ctrl #(
  parameter int unsigned ROW_W     = 3,
  parameter int unsigned COL_W     = 3,
  parameter int unsigned PW_W      = 16,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2,
  parameter logic [31:0] BASE_ADR  = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic [2**ROW_W-1:0]   wl_sel,
  output logic [2**COL_W-1:0]   bl_sel,
  output logic                  set_en,
  output logic                  reset_en,
  output logic                  form_en,
  output logic                  read_en,
  output logic                  sa_strobe,
  input  logic                  sa_out,
  output logic                  irq
);

  localparam int unsigned ROWS = 2**ROW_W;
  localparam int unsigned COLS = 2**COL_W;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;
  localparam logic [1:0] OP_FORM  = 2'b11;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_ADDR   = 2'd1;
  localparam logic [1:0] REG_PW     = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_DONE} state_t;

  state_t            state;
  logic [PW_W-1:0]   cnt;
  logic [PW_W-1:0]   pw;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [1:0]        op;
  logic              busy, done, err, rbit;

  logic              req, hit, new_req, acc, cfg_wr, cfg_ok, rd_status, start;
  logic [1:0]        reg_idx;
  logic [31:0]       rd_word, pw_merge;
  logic [PW_W-1:0]   pw_next;
  logic              unused_ok;

  assign unused_ok = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  // Bus decode: the request is acked one cycle later and takes effect at the end of the ack cycle
  always_comb begin
    req       = wbs_stb_i & wbs_cyc_i;
    hit       = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    reg_idx   = wbs_adr_i[3:2];
    new_req   = req & ~wbs_ack_o;
    acc       = req & wbs_ack_o & hit;
    cfg_wr    = acc & wbs_we_i & (reg_idx != REG_STATUS);
    cfg_ok    = cfg_wr & ~busy;
    rd_status = acc & ~wbs_we_i & (reg_idx == REG_STATUS);
    start     = cfg_ok & (reg_idx == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[0];

    pw_merge = 32'(pw);
    if (wbs_sel_i[0]) pw_merge[7:0]  = wbs_dat_i[7:0];
    if (wbs_sel_i[1]) pw_merge[15:8] = wbs_dat_i[15:8];
    pw_next = PW_W'(pw_merge);
    if (pw_next == '0) pw_next = PW_W'(1);

    rd_word = '0;
    case (reg_idx)
      REG_CTRL:   rd_word[2:1] = op;
      REG_ADDR: begin
        rd_word[ROW_W-1:0] = row;
        rd_word[COL_W+7:8] = col;
      end
      REG_PW:     rd_word[PW_W-1:0] = pw;
      default:    rd_word[3:0] = {rbit, err, done, busy};
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pw        <= PW_W'(1);
      row       <= '0;
      col       <= '0;
      op        <= OP_READ;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rbit      <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      wl_sel    <= '0;
      bl_sel    <= '0;
      set_en    <= 1'b0;
      reset_en  <= 1'b0;
      form_en   <= 1'b0;
      read_en   <= 1'b0;
      sa_strobe <= 1'b0;
      irq       <= 1'b0;
    end else begin
      wbs_ack_o <= new_req;
      wbs_dat_o <= (new_req & hit & ~wbs_we_i) ? rd_word : '0;

      if (rd_status) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (cfg_wr & busy) err <= 1'b1;

      // Configuration registers are frozen while a sequence is in flight
      if (cfg_ok) begin
        case (reg_idx)
          REG_CTRL: if (wbs_sel_i[0]) op <= wbs_dat_i[2:1];
          REG_ADDR: begin
            if (wbs_sel_i[0]) row <= wbs_dat_i[ROW_W-1:0];
            if (wbs_sel_i[1]) col <= wbs_dat_i[COL_W+7:8];
          end
          REG_PW:   pw <= pw_next;
          default:  ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_SETUP;
            busy   <= 1'b1;
            cnt    <= PW_W'(SETUP_CYC - 1);
            wl_sel <= ROWS'(1) << row;
            bl_sel <= COLS'(1) << col;
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            state     <= S_PULSE;
            cnt       <= pw - PW_W'(1);
            read_en   <= (op == OP_READ);
            set_en    <= (op == OP_SET);
            reset_en  <= (op == OP_RESET);
            form_en   <= (op == OP_FORM);
            sa_strobe <= (op == OP_READ) && (pw == PW_W'(1));
          end else begin
            cnt <= cnt - PW_W'(1);
          end
        end
        S_PULSE: begin
          // Strobe is raised so that it lines up with the final pulse cycle
          if (cnt == '0) begin
            state     <= S_HOLD;
            cnt       <= PW_W'(HOLD_CYC - 1);
            read_en   <= 1'b0;
            set_en    <= 1'b0;
            reset_en  <= 1'b0;
            form_en   <= 1'b0;
            sa_strobe <= 1'b0;
            if (op == OP_READ) rbit <= sa_out;
          end else begin
            cnt       <= cnt - PW_W'(1);
            sa_strobe <= (op == OP_READ) && (cnt == PW_W'(1));
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            state  <= S_DONE;
            wl_sel <= '0;
            bl_sel <= '0;
            irq    <= 1'b1;
          end else begin
            cnt <= cnt - PW_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          irq   <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rram_pulse_ctrl.sv
// Self-checking bench for rram_pulse_ctrl: directed and randomized sequences
// compared cycle-by-cycle against timing windows derived from the register settings.
module tb_rram_pulse_ctrl;

  localparam int unsigned S = 2;
  localparam int unsigned H = 2;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [1:0] OP_READ = 2'b00, OP_SET = 2'b01, OP_RESET = 2'b10, OP_FORM = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we, ack;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w, dat_r;
  logic [7:0]  wl_sel, bl_sel;
  logic        set_en, reset_en, form_en, read_en, sa_strobe, sa_out, irq;
  logic [21:0] obs;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  int unsigned pw_m, row_m, col_m;
  logic [1:0]  op_m;
  logic        err_m, done_m, rbit_m;

  always #5 clk = ~clk;

  rram_pulse_ctrl dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .wl_sel(wl_sel), .bl_sel(bl_sel), .set_en(set_en), .reset_en(reset_en),
    .form_en(form_en), .read_en(read_en), .sa_strobe(sa_strobe), .sa_out(sa_out), .irq(irq)
  );

  assign obs = {wl_sel, bl_sel, set_en, reset_en, form_en, read_en, sa_strobe, irq};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic bus_drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d; sel = s;
  endtask

  task automatic bus_idle;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; dat_w = '0; sel = '0;
  endtask

  // One bus transfer; returns one cycle after the ack cycle
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd);
    bit got;
    got = 1'b0;
    bus_drive(w, a, d, s);
    for (int i = 0; i < 4; i++) begin
      tick;
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    check("ack_seen", 32'(got), 32'd1);
    rd = dat_r;
    tick;
    bus_idle;
    check("ack_one_cycle", 32'(ack), 32'd0);
    check("dat_idle_zero", dat_r, 32'd0);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    wb_xfer(1'b1, a, d, s, rd);
  endtask

  task automatic wb_read_check(input string tag, input logic [31:0] a, input logic [31:0] want);
    logic [31:0] rd;
    wb_xfer(1'b0, a, 32'd0, 4'hF, rd);
    check(tag, rd, want);
  endtask

  function automatic logic [31:0] status_m(input logic busy);
    return 32'({rbit_m, err_m, done_m, busy});
  endfunction

  function automatic logic [31:0] addr_m;
    return (32'(col_m) << 8) | 32'(row_m);
  endfunction

  task automatic model_reset;
    pw_m = 1; row_m = 0; col_m = 0; op_m = OP_READ;
    err_m = 1'b0; done_m = 1'b0; rbit_m = 1'b0;
  endtask

  // Program and launch one operation, then compare every cycle against the expected windows.
  // inj: 0 none, 1 ADDR+CTRL writes mid-pulse, 2 STATUS read in DONE, 3 start write in DONE
  task automatic run_seq(input logic [1:0] op, input int unsigned row, input int unsigned col,
                         input int unsigned pw, input bit rand_sa, input int unsigned inj);
    int unsigned t, ack_k;
    logic        sel_on, en_on;
    logic [7:0]  wl_e, bl_e;
    logic [21:0] e;
    wb_write(BASE + 32'd4, (32'(col) << 8) | 32'(row), 4'hF);
    row_m = row; col_m = col;
    wb_write(BASE + 32'd8, pw, 4'hF);
    pw_m = ((pw & 32'hFFFF) == 0) ? 1 : (pw & 32'hFFFF);
    wb_write(BASE, 32'({op, 1'b1}), 4'hF);
    op_m = op;
    t = S + pw_m + H + 1;
    ack_k = 0;
    for (int unsigned k = 1; k <= t + 3; k++) begin
      sa_out = rand_sa ? 1'($urandom) : 1'(k == S + pw_m);
      sel_on = (k <= S + pw_m + H);
      en_on  = (k > S) && (k <= S + pw_m);
      wl_e   = sel_on ? 8'(1 << row) : 8'h00;
      bl_e   = sel_on ? 8'(1 << col) : 8'h00;
      e = {wl_e, bl_e, en_on && op == OP_SET, en_on && op == OP_RESET, en_on && op == OP_FORM,
           en_on && op == OP_READ, (op == OP_READ) && (k == S + pw_m), 1'(k == t)};
      check("seq_outputs", 32'(obs), 32'(e));
      if (op == OP_READ && k == S + pw_m) rbit_m = sa_out;
      if (inj != 0 && k == ack_k) begin
        check("inj_ack", 32'(ack), 32'd1);
        if (inj == 2) begin
          check("status_in_done", dat_r, status_m(1'b1));
          done_m = 1'b0;
          err_m  = 1'b0;
        end else begin
          err_m = 1'b1;
        end
      end
      if (k == ack_k + 1) bus_idle;
      if ((inj == 1 && k == S + 2) ) begin bus_drive(1'b1, BASE + 32'd4, $urandom, 4'hF); ack_k = k + 1; end
      if ((inj == 1 && k == S + 5) ) begin bus_drive(1'b1, BASE, 32'h7, 4'hF); ack_k = k + 1; end
      if ((inj == 2 && k == t - 1)) begin bus_drive(1'b0, BASE + 32'd12, 32'd0, 4'hF); ack_k = k + 1; end
      if ((inj == 3 && k == t - 1)) begin bus_drive(1'b1, BASE, 32'h3, 4'hF); ack_k = k + 1; end
      tick;
    end
    done_m = 1'b1;
  endtask

  task automatic read_status_clear;
    wb_read_check("status", BASE + 32'd12, status_m(1'b0));
    done_m = 1'b0;
    err_m  = 1'b0;
    wb_read_check("status_reread", BASE + 32'd12, status_m(1'b0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r_op;
    int unsigned r_row, r_col, r_pw, r_inj;

    rst_n = 1'b0;
    sa_out = 1'b0;
    bus_idle;
    model_reset;
    repeat (3) tick;
    check("reset_outputs", 32'(obs), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_dat", dat_r, 32'd0);
    rst_n = 1'b1;
    tick;
    wb_read_check("reset_status", BASE + 32'd12, 32'h0);
    wb_read_check("reset_pw", BASE + 32'd8, 32'h1);
    wb_read_check("reset_addr", BASE + 32'd4, 32'h0);
    wb_read_check("reset_ctrl", BASE, 32'h0);

    // SET at row 2, col 5, PW 4
    run_seq(OP_SET, 2, 5, 4, 1'b0, 0);
    wb_read_check("set_status", BASE + 32'd12, 32'h2);
    done_m = 1'b0;
    wb_read_check("set_status_clr", BASE + 32'd12, 32'h0);

    // READ with sense-amp high only in the last pulse cycle
    run_seq(OP_READ, 6, 1, 3, 1'b0, 0);
    wb_read_check("read_status", BASE + 32'd12, 32'hA);
    done_m = 1'b0;
    wb_read_check("read_status_clr", BASE + 32'd12, status_m(1'b0));

    // PW of zero behaves as one
    wb_write(BASE + 32'd8, 32'h0, 4'hF);
    wb_read_check("pw_zero_as_one", BASE + 32'd8, 32'h1);
    run_seq(OP_FORM, 0, 7, 0, 1'b1, 0);
    read_status_clear;

    // RESET with config writes mid-pulse
    run_seq(OP_RESET, 4, 3, 10, 1'b1, 1);
    wb_read_check("addr_unchanged", BASE + 32'd4, addr_m());
    wb_read_check("ctrl_unchanged", BASE, 32'({op_m, 1'b0}));
    read_status_clear;

    // Simultaneous events in the DONE cycle
    run_seq(OP_SET, 1, 1, 2, 1'b1, 2);
    read_status_clear;
    run_seq(OP_READ, 3, 4, 2, 1'b1, 3);
    read_status_clear;

    // Byte lanes and address decode
    wb_write(BASE + 32'd8, 32'hABCD_1234, 4'b0001);
    pw_m = (pw_m & 32'hFF00) | 32'h34;
    wb_read_check("pw_lane0", BASE + 32'd8, 32'(pw_m));
    wb_write(BASE + 32'd8, 32'h0000_5600, 4'b0010);
    pw_m = (pw_m & 32'h00FF) | 32'h5600;
    wb_read_check("pw_lane1", BASE + 32'd8, 32'(pw_m));
    wb_write(32'h4000_0004, 32'h0000_0707, 4'hF);
    wb_read_check("miss_write_dropped", BASE + 32'd4, addr_m());
    wb_read_check("miss_read_zero", 32'h4000_0008, 32'h0);

    // Longest pulse width
    run_seq(OP_SET, 7, 7, 32'hFFFF, 1'b0, 0);
    read_status_clear;

    // Randomized operations
    for (int i = 0; i < 12; i++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_row = $urandom_range(0, 7);
      r_col = $urandom_range(0, 7);
      r_pw  = $urandom_range(0, 12);
      r_inj = $urandom_range(0, 3);
      if (r_inj == 1 && r_pw < 7) r_pw = r_pw + 7;
      run_seq(r_op, r_row, r_col, r_pw, 1'b1, r_inj);
      read_status_clear;
      wb_read_check("rand_ctrl", BASE, 32'({op_m, 1'b0}));
      wb_read_check("rand_addr", BASE + 32'd4, addr_m());
      wb_read_check("rand_pw", BASE + 32'd8, 32'(pw_m));
    end

    // Reset in the middle of a pulse
    wb_write(BASE + 32'd4, 32'h0000_0304, 4'hF);
    wb_write(BASE + 32'd8, 32'd20, 4'hF);
    wb_write(BASE, 32'h3, 4'hF);
    repeat (S + 2) tick;
    check("pre_reset_set_en", 32'(set_en), 32'd1);
    rst_n = 1'b0;
    tick;
    check("midreset_outputs", 32'(obs), 32'd0);
    rst_n = 1'b1;
    model_reset;
    for (int i = 0; i < 30; i++) begin
      check("post_reset_quiet", 32'(obs), 32'd0);
      tick;
    end
    wb_read_check("post_reset_status", BASE + 32'd12, 32'h0);
    wb_read_check("post_reset_pw", BASE + 32'd8, 32'h1);
    wb_read_check("post_reset_addr", BASE + 32'd4, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
